// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: bus widths,
// stall-vector stage indices, sequencer states and the nested stall-mask helper.
package pipeline_ctrl_pkg;

    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned STALL_BUS_WIDTH = 6;

    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    typedef enum logic [1:0] {
        PCTRL_RUN,
        PCTRL_MC_BUSY,
        PCTRL_MC_DONE,
        PCTRL_FLUSH_PEND
    } pctrl_state_e;

    // A stalling stage freezes itself and every stage upstream of it.
    function automatic logic [STALL_BUS_WIDTH-1:0] stall_mask(input int unsigned top);
        logic [STALL_BUS_WIDTH-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < STALL_BUS_WIDTH; i++) begin
            if (i <= top) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline; also sequences
// multi-cycle mul/div ops in EX and defers flushes behind memory stalls.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 33
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_stall_req,
    input  logic                       id_load_use,
    input  logic                       ex_mc_start,
    input  logic                       ex_mc_is_div,
    input  logic                       mem_stall_req,
    input  logic                       flush_req,
    input  logic [ADDR_W-1:0]          flush_pc_in,
    output logic [STALL_BUS_WIDTH-1:0] stall,
    output logic                       flush,
    output logic [ADDR_W-1:0]          flush_pc,
    output logic                       ex_mc_done,
    output logic                       ex_mc_abort
);

    localparam int unsigned MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES);

    // Counter holds the number of MC_BUSY cycles left after the current one.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 3);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 3);

    pctrl_state_e               state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic                       flush_q;
    logic [ADDR_W-1:0]          flush_pc_q;
    logic                       done_q;
    logic                       abort_q;
    logic [ADDR_W-1:0]          pend_pc_q;
    logic                       pend_abort_q;

    logic                       ex_busy;
    logic                       op_live;
    logic                       mc_short;
    logic [CNT_W-1:0]           mc_load;
    logic [STALL_BUS_WIDTH-1:0] stall_vec;

    always_comb begin
        ex_busy  = ((state_q == PCTRL_RUN) && ex_mc_start)
                || (state_q == PCTRL_MC_BUSY)
                || ((state_q == PCTRL_MC_DONE) && mem_stall_req);
        op_live  = (state_q == PCTRL_MC_BUSY) || (state_q == PCTRL_MC_DONE)
                || ((state_q == PCTRL_RUN) && ex_mc_start);
        mc_short = ex_mc_is_div ? (DIV_CYCLES == 2) : (MUL_CYCLES == 2);
        mc_load  = ex_mc_is_div ? DIV_LOAD : MUL_LOAD;

        stall_vec = '0;
        if (!flush_q) begin
            if (mem_stall_req) stall_vec = stall_vec | stall_mask(STALL_MEM);
            if (ex_busy)       stall_vec = stall_vec | stall_mask(STALL_EX);
            if (id_load_use)   stall_vec = stall_vec | stall_mask(STALL_ID);
            if (if_stall_req)  stall_vec = stall_vec | stall_mask(STALL_IF);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PCTRL_RUN;
            cnt_q        <= '0;
            flush_q      <= 1'b0;
            flush_pc_q   <= '0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            pend_pc_q    <= '0;
            pend_abort_q <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;

            if (state_q == PCTRL_FLUSH_PEND) begin
                // Further flush requests are ignored until the pending one issues.
                if (!mem_stall_req) begin
                    state_q      <= PCTRL_RUN;
                    flush_q      <= 1'b1;
                    flush_pc_q   <= pend_pc_q;
                    abort_q      <= pend_abort_q;
                    pend_abort_q <= 1'b0;
                end
            end else if (flush_req) begin
                cnt_q <= '0;
                if (mem_stall_req) begin
                    state_q      <= PCTRL_FLUSH_PEND;
                    pend_pc_q    <= flush_pc_in;
                    pend_abort_q <= op_live;
                end else begin
                    state_q    <= PCTRL_RUN;
                    flush_q    <= 1'b1;
                    flush_pc_q <= flush_pc_in;
                    abort_q    <= op_live;
                end
            end else begin
                case (state_q)
                    PCTRL_RUN: begin
                        if (ex_mc_start) begin
                            if (mc_short) begin
                                state_q <= PCTRL_MC_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= PCTRL_MC_BUSY;
                                cnt_q   <= mc_load;
                            end
                        end
                    end
                    PCTRL_MC_BUSY: begin
                        if (cnt_q == '0) begin
                            state_q <= PCTRL_MC_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    PCTRL_MC_DONE: begin
                        if (mem_stall_req) done_q  <= 1'b1;
                        else               state_q <= PCTRL_RUN;
                    end
                    default: state_q <= PCTRL_RUN;
                endcase
            end
        end
    end

    assign stall       = stall_vec;
    assign flush       = flush_q;
    assign flush_pc    = flush_pc_q;
    assign ex_mc_done  = done_q;
    assign ex_mc_abort = abort_q;

endmodule
